// File: rtl/la_oai_pipe.sv
// la_oai_pipe -- pipelined OR-AND(-INVERT) array with valid/ready flow control.
//
// Each of W independent bit lanes computes
//    f = AND over groups g of (OR over inputs n of operand[g][n][lane])
// and the lane result is ~f (INV=1) or f (INV=0). Evaluation is purely
// combinational ahead of stage 0. The STAGES registers behind it only carry
// results, and they form a skid-free elastic pipeline.
//
// Ports
//    clk        rising-edge clock
//    reset      synchronous, active-high; clears all valid bits and data
//    in_valid   upstream offers in_data
//    in_ready   pipe accepts in_data this cycle (forced low during reset)
//    in_data    G*N*W operand bits; lane l, group g, input n at (g*N+n)*W+l
//    out_valid  out_z holds a result
//    out_ready  downstream accepts out_z this cycle
//    out_z      W-bit result from the last stage
//    busy       any stage holds a valid result
module la_oai_pipe #(
   parameter int W      = 4,
   parameter int G      = 3,
   parameter int N      = 2,
   parameter int STAGES = 2,
   parameter int INV    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [G*N*W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_z,
   output logic             busy
);

   if (W < 1) begin : g_bad_w
      $error("la_oai_pipe: W must be at least 1");
   end
   if (G < 1 || G > 8) begin : g_bad_g
      $error("la_oai_pipe: G must be in 1..8");
   end
   if (N < 1 || N > 4) begin : g_bad_n
      $error("la_oai_pipe: N must be in 1..4");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("la_oai_pipe: STAGES must be in 1..4");
   end
   if (INV != 0 && INV != 1) begin : g_bad_inv
      $error("la_oai_pipe: INV must be 0 or 1");
   end

   // Operand (g,n) occupies a contiguous W-bit slice, so the OR/AND tree
   // can be built lane-parallel on whole slices.
   logic [W-1:0] grp_or [G];
   logic [W-1:0] and_f;
   logic [W-1:0] eval_z;

   always_comb begin
      and_f = '1;
      for (int g = 0; g < G; g++) begin
         grp_or[g] = '0;
         for (int n = 0; n < N; n++) begin
            grp_or[g] = grp_or[g] | in_data[(g*N+n)*W +: W];
         end
         and_f = and_f & grp_or[g];
      end
      eval_z = (INV != 0) ? ~and_f : and_f;
   end

   logic [STAGES-1:0] valid_q, valid_d;
   logic [W-1:0]      data_q [STAGES];
   logic [W-1:0]      data_d [STAGES];
   logic [STAGES-1:0] stage_rdy;
   logic              holes;

   // A stage can load when it, or any stage downstream of it, has room, or
   // the last stage is draining. Computing it from a running "hole seen"
   // flag keeps the ready chain free of a self-referencing vector.
   always_comb begin
      holes = 1'b0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         holes        = holes | ~valid_q[k];
         stage_rdy[k] = out_ready | holes;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (stage_rdy[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) begin
            data_d[0] = eval_z;
         end
      end
      for (int k = 1; k < STAGES; k++) begin
         if (stage_rdy[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = stage_rdy[0] & ~reset;
   assign out_valid = valid_q[STAGES-1];
   assign out_z     = data_q[STAGES-1];
   assign busy      = |valid_q;

endmodule

// File: tb/tb_la_oai_pipe.sv
module tb_la_oai_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [23:0] in_data;
   logic        out_ready;
   logic        in_ready, out_valid, busy;
   logic [3:0]  out_z;
   logic        in_ready0, out_valid0, busy0;
   logic [3:0]  out_z0;

   int n_cmp  = 0;
   int n_fail = 0;

   // captured at the end of each step, before the next rising edge
   logic       s_in_ready, s_out_valid, s_busy, s_out_valid0;
   logic [3:0] s_out_z, s_out_z0;

   always #5 clk = ~clk;

   la_oai_pipe dut_inv (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .busy(busy)
   );

   la_oai_pipe #(.INV(0)) dut_or (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
      .out_z(out_z0), .busy(busy0)
   );

   // Reference: lane result straight from the boolean definition.
   function automatic logic [3:0] ref_z(input logic [23:0] d, input bit inv);
      logic [3:0] r;
      for (int l = 0; l < 4; l++) begin
         bit all_grp = 1'b1;
         for (int g = 0; g < 3; g++) begin
            bit any_in = 1'b0;
            for (int n = 0; n < 2; n++) begin
               if (d[(g*2+n)*4+l]) any_in = 1'b1;
            end
            if (!any_in) all_grp = 1'b0;
         end
         r[l] = inv ? !all_grp : all_grp;
      end
      return r;
   endfunction

   // Drive one cycle of inputs and capture outputs before the next edge.
   task automatic step(input logic r, input logic v, input logic [23:0] d,
                       input logic ordy);
      @(negedge clk);
      reset = r; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      s_in_ready   = in_ready;
      s_out_valid  = out_valid;
      s_out_z      = out_z;
      s_busy       = busy;
      s_out_valid0 = out_valid0;
      s_out_z0     = out_z0;
   endtask

   // One input in cycle 0, then idle; reports which cycles had out_valid.
   task automatic single_shot(input logic [23:0] d, output int vcount,
                              output int vcycle, output logic [3:0] z,
                              output logic [3:0] z0);
      vcount = 0; vcycle = -1; z = 'x; z0 = 'x;
      for (int c = 0; c < 6; c++) begin
         step(1'b0, c == 0, (c == 0) ? d : 24'h0, 1'b1);
         if (s_out_valid) begin
            vcount++;
            if (vcycle < 0) begin
               vcycle = c; z = s_out_z; z0 = s_out_z0;
            end
         end
      end
   endtask

   task automatic test_reset();
      step(1'b1, 1'b0, 24'h0, 1'b1);
      step(1'b1, 1'b1, 24'hFFFFFF, 1'b1);
      n_cmp++;
      if (s_in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready_low got=%b want=0", s_in_ready);
      end
      step(1'b0, 1'b0, 24'h0, 1'b1);
      n_cmp++;
      if ({s_out_valid, s_busy, s_out_z, s_in_ready} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state got valid=%b busy=%b z=%h rdy=%b want 0 0 0 1",
                  s_out_valid, s_busy, s_out_z, s_in_ready);
      end
   endtask

   task automatic test_all_ones();
      int vc, vcy; logic [3:0] z, z0;
      single_shot(24'hFFFFFF, vc, vcy, z, z0);
      n_cmp++;
      if (vcy !== 2) begin
         n_fail++; $display("FAIL latency got=%0d want=2", vcy);
      end
      n_cmp++;
      if (vc !== 1) begin
         n_fail++; $display("FAIL valid_cycles got=%0d want=1", vc);
      end
      n_cmp++;
      if (z !== 4'b0000 || z0 !== 4'b1111) begin
         n_fail++; $display("FAIL all_ones got=%b/%b want=0000/1111", z, z0);
      end
   endtask

   task automatic test_group_zero();
      int vc, vcy; logic [3:0] z, z0;
      single_shot(24'hFF00FF, vc, vcy, z, z0);
      n_cmp++;
      if (vc !== 1 || vcy !== 2) begin
         n_fail++; $display("FAIL group_zero_timing got=%0d@%0d want=1@2", vc, vcy);
      end
      n_cmp++;
      if (z !== 4'b1111) begin
         n_fail++; $display("FAIL group_zero_oai got=%b want=1111", z);
      end
      n_cmp++;
      if (z0 !== 4'b0000) begin
         n_fail++; $display("FAIL group_zero_oa got=%b want=0000", z0);
      end
   endtask

   task automatic test_lane_mix();
      int vc, vcy; logic [3:0] z, z0;
      // lane0: input0 of every group; lane1: groups 0,1 only; lanes 2-3 zero
      single_shot(24'h012323, vc, vcy, z, z0);
      n_cmp++;
      if (z !== 4'b1110 || vcy !== 2) begin
         n_fail++; $display("FAIL lane_mix got=%b@%0d want=1110@2", z, vcy);
      end
      n_cmp++;
      if (z0 !== 4'b0001) begin
         n_fail++; $display("FAIL lane_mix_oa got=%b want=0001", z0);
      end
   endtask

   task automatic test_back_to_back();
      logic [23:0] vec [8];
      int k = 0;
      for (int i = 0; i < 8; i++) vec[i] = 24'($urandom);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, i < 8, (i < 8) ? vec[i] : 24'h0, 1'b1);
         if (i < 8) begin
            n_cmp++;
            if (s_in_ready !== 1'b1) begin
               n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=1", i, s_in_ready);
            end
         end
         if (s_out_valid === 1'b1) begin
            n_cmp++;
            if (k >= 8 || i != k + 2 || s_out_z !== ref_z(vec[k], 1'b1)
                || s_out_z0 !== ref_z(vec[k], 1'b0)) begin
               n_fail++;
               $display("FAIL b2b_out cyc=%0d idx=%0d got=%h/%h", i, k, s_out_z, s_out_z0);
            end
            k++;
         end
      end
      n_cmp++;
      if (k !== 8) begin
         n_fail++; $display("FAIL b2b_count got=%0d want=8", k);
      end
   endtask

   task automatic test_backpressure();
      logic [23:0] vec [3];
      logic [23:0] sb [$];
      logic [3:0]  held;
      int acc = 0, nxt = 0, outs = 0;
      for (int i = 0; i < 3; i++) vec[i] = 24'($urandom);
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b1, vec[nxt], 1'b0);
         if (s_in_ready) begin
            sb.push_back(vec[nxt]); acc++; nxt++;
         end
         if (c == 2) held = s_out_z;
         if (c >= 2) begin
            n_cmp++;
            if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1 || s_out_z !== held) begin
               n_fail++;
               $display("FAIL stall_hold cyc=%0d rdy=%b valid=%b z=%h held=%h",
                        c, s_in_ready, s_out_valid, s_out_z, held);
            end
         end
      end
      n_cmp++;
      if (acc !== 2 || held !== ref_z(vec[0], 1'b1)) begin
         n_fail++; $display("FAIL stall_accept got=%0d z=%h want=2 z=%h",
                            acc, held, ref_z(vec[0], 1'b1));
      end
      for (int c = 0; c < 8; c++) begin
         step(1'b0, nxt < 3, vec[nxt < 3 ? nxt : 2], 1'b1);
         if (c == 0) begin
            n_cmp++;
            if (s_in_ready !== 1'b1) begin
               n_fail++; $display("FAIL release_ready got=%b want=1", s_in_ready);
            end
         end
         if (s_out_valid) begin
            n_cmp++;
            if (sb.size() == 0 || s_out_z !== ref_z(sb[0], 1'b1)) begin
               n_fail++; $display("FAIL release_order idx=%0d got=%h", outs, s_out_z);
            end
            if (sb.size() != 0) void'(sb.pop_front());
            outs++;
         end
         if (nxt < 3 && s_in_ready) begin
            sb.push_back(vec[nxt]); nxt++;
         end
      end
      n_cmp++;
      if (outs !== 3) begin
         n_fail++; $display("FAIL release_count got=%0d want=3", outs);
      end
   endtask

   task automatic test_full_reset();
      int stale = 0;
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 24'hFFFFFF, 1'b0);
      step(1'b1, 1'b0, 24'h0, 1'b0);
      step(1'b0, 1'b0, 24'h0, 1'b1);
      n_cmp++;
      if ({s_out_valid, s_busy, s_out_z, s_in_ready} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL full_reset got valid=%b busy=%b z=%h rdy=%b want 0 0 0 1",
                  s_out_valid, s_busy, s_out_z, s_in_ready);
      end
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 1'b0, 24'h0, 1'b1);
         if (s_out_valid || s_out_valid0) stale++;
      end
      n_cmp++;
      if (stale !== 0) begin
         n_fail++; $display("FAIL stale_after_reset got=%0d want=0", stale);
      end
   endtask

   task automatic test_random();
      logic [23:0] sb [$];
      int errs = 0, outs = 0, drain = 0;
      for (int c = 0; c < 300; c++) begin
         logic v, o; logic [23:0] d;
         v = 1'($urandom_range(1, 0));
         o = ($urandom_range(3, 0) != 0);
         d = 24'($urandom);
         step(1'b0, v, d, o);
         n_cmp++;
         if (s_busy !== (sb.size() != 0) || s_out_valid0 !== s_out_valid) begin
            n_fail++; $display("FAIL rand_busy cyc=%0d got=%b want=%0d", c, s_busy, sb.size() != 0);
         end
         if (s_out_valid && o) begin
            n_cmp++;
            if (sb.size() == 0 || s_out_z !== ref_z(sb[0], 1'b1)
                || s_out_z0 !== ref_z(sb[0], 1'b0)) begin
               n_fail++; errs++;
               if (errs < 5) $display("FAIL rand_out cyc=%0d got=%h/%h", c, s_out_z, s_out_z0);
            end
            if (sb.size() != 0) void'(sb.pop_front());
            outs++;
         end
         if (v && s_in_ready) sb.push_back(d);
      end
      while (sb.size() != 0 && drain < 20) begin
         step(1'b0, 1'b0, 24'h0, 1'b1);
         if (s_out_valid) begin
            n_cmp++;
            if (s_out_z !== ref_z(sb[0], 1'b1)) begin
               n_fail++; $display("FAIL rand_drain got=%h want=%h", s_out_z, ref_z(sb[0], 1'b1));
            end
            void'(sb.pop_front());
         end
         drain++;
      end
      n_cmp++;
      if (sb.size() != 0 || outs == 0) begin
         n_fail++; $display("FAIL rand_drain_timeout left=%0d outs=%0d", sb.size(), outs);
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_all_ones();
      test_group_zero();
      test_lane_mix();
      test_back_to_back();
      test_backpressure();
      test_full_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/la_oai_pipe.md
LA_OAI_PIPE -- requirements
Module: la_oai_pipe

Interface
REQ-001 SHALL have parameter W, default 4: number of independent bit lanes.
REQ-002 SHALL have parameter G, default 3, legal 1-8: number of OR groups.
REQ-003 SHALL have parameter N, default 2, legal 1-4: inputs per OR group.
REQ-004 SHALL have parameter STAGES, default 2, legal 1-4: pipeline register depth.
REQ-005 SHALL have parameter INV, default 1: 1 = OR-AND-INVERT, 0 = OR-AND (no output inversion).
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: upstream offers in_data this cycle.
REQ-009 SHALL have port in_ready, output, 1: block accepts in_data this cycle.
REQ-010 SHALL have port in_data, input, G*N*W: operands; lane l, group g, input n at bit (g*N+n)*W+l.
REQ-011 SHALL have port out_valid, output, 1: out_z holds a valid result.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts out_z this cycle.
REQ-013 SHALL have port out_z, output, W: result vector.
REQ-014 SHALL have port busy, output, 1: high when any stage holds valid data.

Function
REQ-015 Per lane l: f = AND over g of (OR over n of operand[g][n][l]); out_z[l] = ~f if INV=1, else f.
REQ-016 Evaluation SHALL occur combinationally before stage 0; stages 1..STAGES-1 carry the result only. Each stage holds a W-bit data register and a valid bit.
REQ-017 Transfer in: in_valid & in_ready on a rising edge. Transfer out: out_valid & out_ready on a rising edge.
REQ-018 Stage k SHALL load when it is empty or its contents leave in the same cycle. The last stage leaves on out_ready. Stage k<last leaves when stage k+1 loads.
REQ-019 in_ready SHALL equal (~valid[0] | stage 0 leaving) & ~reset; the ready chain is combinational from out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, with out_ready held high.
REQ-021 Throughput SHALL be one result per cycle when out_ready stays high; no bubbles inserted.
REQ-022 While out_valid & ~out_ready, out_z and out_valid SHALL hold stable.
REQ-023 When the pipe is full and out_ready is high, a simultaneous input transfer SHALL be accepted in the same cycle.
REQ-024 When the pipe is full and out_ready is low, in_ready SHALL be 0 and no data SHALL be lost or overwritten.
REQ-025 Results SHALL leave in acceptance order.
REQ-026 in_data SHALL be ignored when in_valid=0. Data registers of empty stages SHALL keep their prior value.
REQ-027 out_valid SHALL equal valid[STAGES-1], and out_z SHALL equal data[STAGES-1].
REQ-028 busy SHALL be the OR of all valid bits.
REQ-029 Parameters outside their legal range SHALL be rejected at elaboration.

Reset
REQ-030 While reset=1 at a clock edge, all valid bits and data registers SHALL clear to 0. The cycle after, out_valid=0, out_z=0 and busy=0.
REQ-031 in_ready SHALL be 0 during any cycle with reset=1. It SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results, including a held output. No partial result SHALL appear after reset.

Verification
REQ-033 Defaults, out_ready=1, one transfer with in_data all ones (24'hFFFFFF) -> out_z=4'b0000 with out_valid high exactly 2 cycles later, for exactly one cycle.
REQ-034 Defaults, group 1 inputs all 0, groups 0 and 2 all ones -> out_z=4'b1111. Repeat with INV=0 -> out_z=4'b0000.
REQ-035 Lane mix, defaults: lane 0 has one input high in every group, lane 1 has group 2 all zero, lanes 2-3 all zero -> out_z=4'b1110.
REQ-036 Back-to-back stream of 8 random vectors with out_ready=1 -> 8 consecutive out_valid cycles, each matching the model in order.
REQ-037 out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 accepted, then in_ready=0 and out_z held. Raise out_ready -> in_ready high the same cycle, and order is preserved.
REQ-038 Full pipe, then reset pulsed for 1 cycle -> next cycle out_valid=0, busy=0, out_z=0, in_ready=1. No stale result ever emerges.
